// File: rtl/trng_cmd_arbiter.sv
// Round-robin arbiter sharing one TRNG_CTRL command port between requesters.
// Caches the loaded config and issues SET_VAR only when a winner's config differs.
module trng_cmd_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int SETUP_CYC   = 2,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_cmd,
    input  logic [12*NUM_REQ-1:0]    req_addr,
    input  logic [28*NUM_REQ-1:0]    req_cfg,
    input  logic [144*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [143:0]             rsp_data,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     ctrl_start,
    output logic [1:0]               ctrl_cmd,
    output logic [11:0]              ctrl_addr,
    output logic [27:0]              ctrl_cfg,
    output logic [143:0]             ctrl_mem_in,
    input  logic                     ctrl_done,
    input  logic                     ctrl_err,
    input  logic [143:0]             ctrl_mem_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + SETUP_CYC + START_CYC + 2) + 1;

    localparam logic [1:0] C_TRNG  = 2'b00;
    localparam logic [1:0] C_SETV  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_SETUP,
        S_CFG_START,
        S_CFG_WAIT,
        S_CMD_SETUP,
        S_CMD_START,
        S_CMD_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [IW-1:0]  r_win;
    logic [IW-1:0]  r_last;
    logic [1:0]     r_cmd;
    logic [11:0]    r_addr;
    logic [27:0]    r_cfg;
    logic [143:0]   r_wdata;
    logic [27:0]    r_loaded_cfg;
    logic           r_cfg_valid;
    logic           r_seen;
    logic           r_seen_err;
    logic [143:0]   r_seen_mem;
    logic [143:0]   r_rsp_data;
    logic           r_rsp_err;
    logic           r_rsp_to;

    logic           w_any;
    logic [IW-1:0]  w_pick;
    logic [IW:0]    w_k;
    logic [1:0]     w_cmd_in;
    logic [11:0]    w_addr_in;
    logic [27:0]    w_cfg_in;
    logic [143:0]   w_wdata_in;
    logic           w_cmpl;
    logic           w_cerr;
    logic [143:0]   w_cmem;
    logic           w_tmo;
    logic           w_cfg_ph;
    logic           w_cmd_ph;
    logic           w_in_resp;

    // Search upward from the last winner, wrapping, for the next request
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_k    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = {1'b0, r_last} + (IW+1)'(i);
            if (w_k >= (IW+1)'(NUM_REQ)) w_k = w_k - (IW+1)'(NUM_REQ);
            if (!w_any && req[w_k[IW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_k[IW-1:0];
            end
        end
    end

    always_comb begin
        w_cmd_in   = '0;
        w_addr_in  = '0;
        w_cfg_in   = '0;
        w_wdata_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IW'(i)) begin
                w_cmd_in   = req_cmd[i*2 +: 2];
                w_addr_in  = req_addr[i*12 +: 12];
                w_cfg_in   = req_cfg[i*28 +: 28];
                w_wdata_in = req_wdata[i*144 +: 144];
            end
        end
    end

    // A completion seen during the start pulse is remembered for the wait state
    assign w_cmpl = r_seen | ctrl_done | ctrl_err;
    assign w_cerr = r_seen ? r_seen_err : ctrl_err;
    assign w_cmem = r_seen ? r_seen_mem : ctrl_mem_out;
    assign w_tmo  = (r_cnt >= CW'(TIMEOUT_CYC));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_cmd_in == C_SETV || !r_cfg_valid ||
                        w_cfg_in != r_loaded_cfg)
                        w_next = S_CFG_SETUP;
                    else
                        w_next = S_CMD_SETUP;
                end
            end
            S_CFG_SETUP: if (r_cnt == CW'(SETUP_CYC-1)) w_next = S_CFG_START;
            S_CFG_START: if (r_cnt == CW'(START_CYC-1)) w_next = S_CFG_WAIT;
            S_CFG_WAIT: begin
                if (w_cmpl) begin
                    if (w_cerr || r_cmd == C_SETV) w_next = S_RESP;
                    else                           w_next = S_CMD_SETUP;
                end else if (w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_CMD_SETUP: if (r_cnt == CW'(SETUP_CYC-1)) w_next = S_CMD_START;
            S_CMD_START: if (r_cnt == CW'(START_CYC-1)) w_next = S_CMD_WAIT;
            S_CMD_WAIT:  if (w_cmpl || w_tmo) w_next = S_RESP;
            S_RESP:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_win        <= '0;
            r_last       <= IW'(NUM_REQ-1);
            r_cmd        <= '0;
            r_addr       <= '0;
            r_cfg        <= '0;
            r_wdata      <= '0;
            r_loaded_cfg <= '0;
            r_cfg_valid  <= 1'b0;
            r_seen       <= 1'b0;
            r_seen_err   <= 1'b0;
            r_seen_mem   <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_to     <= 1'b0;
        end else begin
            r_state <= w_next;
            // Count runs on from start rise through the wait state
            if (w_next != r_state && w_next != S_CFG_WAIT &&
                w_next != S_CMD_WAIT)
                r_cnt <= '0;
            else if (r_state != S_IDLE && r_state != S_RESP)
                r_cnt <= r_cnt + CW'(1);

            if (r_state == S_CFG_START || r_state == S_CFG_WAIT ||
                r_state == S_CMD_START || r_state == S_CMD_WAIT) begin
                if (!r_seen && (ctrl_done || ctrl_err)) begin
                    r_seen     <= 1'b1;
                    r_seen_err <= ctrl_err;
                    r_seen_mem <= ctrl_mem_out;
                end
            end else begin
                r_seen <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_pick;
                        r_cmd   <= w_cmd_in;
                        r_addr  <= w_addr_in;
                        r_cfg   <= w_cfg_in;
                        r_wdata <= w_wdata_in;
                    end
                end
                S_CFG_WAIT: begin
                    if (w_cmpl) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= w_cerr;
                        r_rsp_to   <= 1'b0;
                        if (w_cerr) begin
                            r_cfg_valid <= 1'b0;
                        end else begin
                            r_loaded_cfg <= r_cfg;
                            r_cfg_valid  <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_to    <= 1'b1;
                        r_cfg_valid <= 1'b0;
                    end
                end
                S_CMD_WAIT: begin
                    if (w_cmpl) begin
                        r_rsp_err <= w_cerr;
                        r_rsp_to  <= 1'b0;
                        if (r_cmd == C_READ || r_cmd == C_TRNG)
                            r_rsp_data <= w_cmem;
                        else
                            r_rsp_data <= '0;
                    end else if (w_tmo) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_to    <= 1'b1;
                        r_cfg_valid <= 1'b0;
                    end
                end
                S_RESP:  r_last <= r_win;
                default: ;
            endcase
        end
    end

    assign w_cfg_ph  = (r_state == S_CFG_SETUP) || (r_state == S_CFG_START) ||
                       (r_state == S_CFG_WAIT);
    assign w_cmd_ph  = (r_state == S_CMD_SETUP) || (r_state == S_CMD_START) ||
                       (r_state == S_CMD_WAIT);
    assign w_in_resp = (r_state == S_RESP);

    assign gnt = (r_state == S_IDLE && w_any && !rst) ?
                 (NUM_REQ'(1) << w_pick) : '0;
    assign rsp_valid   = w_in_resp ? (NUM_REQ'(1) << r_win) : '0;
    assign rsp_data    = w_in_resp ? r_rsp_data : '0;
    assign rsp_err     = w_in_resp & r_rsp_err;
    assign rsp_timeout = w_in_resp & r_rsp_to;

    assign ctrl_start  = (r_state == S_CFG_START) || (r_state == S_CMD_START);
    assign ctrl_cmd    = w_cfg_ph ? C_SETV : (w_cmd_ph ? r_cmd : 2'b00);
    assign ctrl_addr   = w_cmd_ph ? r_addr : '0;
    assign ctrl_cfg    = (w_cfg_ph || w_cmd_ph) ? r_cfg : '0;
    assign ctrl_mem_in = (w_cmd_ph && r_cmd == C_WRITE) ? r_wdata : '0;

endmodule

// File: tb/tb_trng_cmd_arbiter.sv
// Directed bench for trng_cmd_arbiter with a behavioural TRNG_CTRL responder.
module tb_trng_cmd_arbiter;

    localparam int N  = 2;
    localparam int TO = 50;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [2*N-1:0]     req_cmd;
    logic [12*N-1:0]    req_addr;
    logic [28*N-1:0]    req_cfg;
    logic [144*N-1:0]   req_wdata;
    logic [N-1:0]       gnt;
    logic [N-1:0]       rsp_valid;
    logic [143:0]       rsp_data;
    logic               rsp_err;
    logic               rsp_timeout;
    logic               ctrl_start;
    logic [1:0]         ctrl_cmd;
    logic [11:0]        ctrl_addr;
    logic [27:0]        ctrl_cfg;
    logic [143:0]       ctrl_mem_in;
    logic               ctrl_done;
    logic               ctrl_err;
    logic [143:0]       ctrl_mem_out;

    trng_cmd_arbiter #(
        .NUM_REQ(N), .SETUP_CYC(2), .START_CYC(2), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_cfg(req_cfg), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .ctrl_start(ctrl_start), .ctrl_cmd(ctrl_cmd),
        .ctrl_addr(ctrl_addr), .ctrl_cfg(ctrl_cfg),
        .ctrl_mem_in(ctrl_mem_in), .ctrl_done(ctrl_done),
        .ctrl_err(ctrl_err), .ctrl_mem_out(ctrl_mem_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: mode 0 = done, 1 = err pulse, 2 = silent; m_lat cycles after start rise
    int           m_mode = 0;
    int           m_lat = 3;
    logic [143:0] m_rdata = '0;
    logic         m_prev = 1'b0;
    logic         m_pend = 1'b0;
    int           m_cnt = 0;
    int           m_w = 0;
    int           st_cyc = 0;
    logic [1:0]   lg_cmd[$];
    logic [11:0]  lg_addr[$];
    logic [27:0]  lg_cfg[$];
    logic [143:0] lg_mem[$];
    int           lg_w[$];
    int           glog[$];

    assign ctrl_mem_out = m_rdata;

    always @(negedge clk) begin
        ctrl_done = 1'b0;
        ctrl_err  = 1'b0;
        if (ctrl_start && !m_prev) begin
            lg_cmd.push_back(ctrl_cmd);
            lg_addr.push_back(ctrl_addr);
            lg_cfg.push_back(ctrl_cfg);
            lg_mem.push_back(ctrl_mem_in);
            m_pend = 1'b1;
            m_cnt  = 0;
            m_w    = 1;
            st_cyc = cyc;
        end else begin
            if (ctrl_start) m_w++;
            if (!ctrl_start && m_prev) lg_w.push_back(m_w);
            if (m_pend) begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    m_pend = 1'b0;
                    if (m_mode == 0) ctrl_done = 1'b1;
                    else if (m_mode == 1) ctrl_err = 1'b1;
                end
            end
        end
        m_prev = ctrl_start;
    end

    always @(negedge clk) begin
        #2;
        if (|gnt) glog.push_back(gnt[1] ? 1 : 0);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [143:0] got,
                       input logic [143:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        lg_cmd.delete();
        lg_addr.delete();
        lg_cfg.delete();
        lg_mem.delete();
        lg_w.delete();
    endtask

    task automatic ld(input int idx, input logic [1:0] c,
                      input logic [11:0] a, input logic [27:0] f,
                      input logic [143:0] w);
        req_cmd[idx*2 +: 2]       = c;
        req_addr[idx*12 +: 12]    = a;
        req_cfg[idx*28 +: 28]     = f;
        req_wdata[idx*144 +: 144] = w;
        req[idx]                  = 1'b1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] c,
                           input logic [11:0] a, input logic [27:0] f,
                           input logic [143:0] w);
        @(negedge clk);
        ld(idx, c, a, f, w);
    endtask

    task automatic wait_rsp(output int who, output logic [N-1:0] rv,
                            output logic [143:0] d, output logic e,
                            output logic t, output int el);
        who = -1;
        rv  = '0;
        d   = '0;
        e   = 1'b0;
        t   = 1'b0;
        el  = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                rv  = rsp_valid;
                who = rsp_valid[1] ? 1 : 0;
                d   = rsp_data;
                e   = rsp_err;
                t   = rsp_timeout;
                el  = cyc - st_cyc;
                req[who] = 1'b0;
                break;
            end
        end
        if (who < 0) chk("rsp_wait", 144'(0), 144'(1));
    endtask

    localparam logic [27:0] CFGA =
        {2'b10, 1'b1, 6'h3F, 6'h15, 3'h0, 9'h1A5, 1'b1};
    localparam logic [27:0] CFGB =
        {2'b10, 1'b1, 6'h3F, 6'h15, 3'h0, 9'h077, 1'b1};
    localparam logic [143:0] WDA =
        144'h9876_5432_10fe_dcba_9876_5432_10fe_dcba_0189;
    localparam logic [143:0] WDB =
        144'h1111_2222_3333_4444_5555_6666_7777_8888_9999;

    initial begin
        int           who;
        int           el;
        int           nr;
        logic [N-1:0] rv;
        logic [143:0] d;
        logic         e;
        logic         t;

        rst       = 1'b1;
        req       = '0;
        req_cmd   = '0;
        req_addr  = '0;
        req_cfg   = '0;
        req_wdata = '0;
        ctrl_done = 1'b0;
        ctrl_err  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", 144'({gnt, rsp_valid, rsp_err, rsp_timeout,
            ctrl_start, ctrl_cmd, ctrl_addr, ctrl_cfg}), 144'(0));
        chk("rst_data", rsp_data | ctrl_mem_in, 144'(0));
        rst = 1'b0;

        // Cold WRITE: SET_VAR then WRITE
        clear_log();
        m_mode = 0;
        m_lat  = 3;
        set_req(0, 2'b10, 12'd30, CFGA, WDA);
        #1;
        chk("t1_gnt", 144'(gnt), 144'(2'b01));
        @(negedge clk);
        chk("t1_c1", 144'({ctrl_start, ctrl_cmd, ctrl_cfg}),
            144'({1'b0, 2'b01, CFGA}));
        @(negedge clk);
        chk("t1_c2", 144'(ctrl_start), 144'(0));
        @(negedge clk);
        chk("t1_s1", 144'(ctrl_start), 144'(1));
        @(negedge clk);
        chk("t1_s2", 144'(ctrl_start), 144'(1));
        wait_rsp(who, rv, d, e, t, el);
        chk("t1_rv", 144'(rv), 144'(2'b01));
        chk("t1_err", 144'({e, t}), 144'(0));
        chk("t1_n", 144'(lg_cmd.size()), 144'(2));
        chk("t1_cmd", 144'({lg_cmd[0], lg_cmd[1]}), 144'(4'b0110));
        chk("t1_addr", 144'(lg_addr[1]), 144'(30));
        chk("t1_mem", lg_mem[1], WDA);
        chk("t1_w", 144'({lg_w[0], lg_w[1]}), 144'({32'd2, 32'd2}));
        chk("t1_el", 144'(el), 144'(4));

        // Cached READ with completion inside the start pulse
        clear_log();
        m_lat   = 1;
        m_rdata = 144'h123456;
        set_req(0, 2'b11, 12'd30, CFGA, '0);
        wait_rsp(who, rv, d, e, t, el);
        chk("t2_data", d, 144'h123456);
        chk("t2_err", 144'({e, t}), 144'(0));
        chk("t2_n", 144'(lg_cmd.size()), 144'(1));
        chk("t2_cmd", 144'({lg_cmd[0], lg_addr[0]}), 144'({2'b11, 12'd30}));
        chk("t2_mem", lg_mem[0], 144'(0));
        chk("t2_el", 144'(el), 144'(3));

        // Address error keeps the config cache
        clear_log();
        m_mode = 1;
        m_lat  = 3;
        set_req(0, 2'b10, 12'd3000, CFGA, WDA);
        wait_rsp(who, rv, d, e, t, el);
        chk("t3_err", 144'({e, t}), 144'(2'b10));
        chk("t3_n", 144'(lg_cmd.size()), 144'(1));
        chk("t3_addr", 144'(lg_addr[0]), 144'(3000));
        clear_log();
        m_mode = 0;
        set_req(0, 2'b11, 12'd30, CFGA, '0);
        wait_rsp(who, rv, d, e, t, el);
        chk("t3_keep", 144'({lg_cmd.size(), 2'(lg_cmd[0])}),
            144'({32'd1, 2'b11}));
        chk("t3_ok", 144'({e, t}), 144'(0));

        // Timeout
        clear_log();
        m_mode = 2;
        set_req(0, 2'b11, 12'd30, CFGA, '0);
        wait_rsp(who, rv, d, e, t, el);
        chk("t4_err", 144'({e, t}), 144'(2'b11));
        chk("t4_data", d, 144'(0));
        chk("t4_el", 144'(el), 144'(TO + 1));
        clear_log();
        m_mode = 0;
        set_req(0, 2'b11, 12'd30, CFGA, '0);
        wait_rsp(who, rv, d, e, t, el);
        chk("t4_reset", 144'({lg_cmd.size(), 2'(lg_cmd[0])}),
            144'({32'd2, 2'b01}));

        // Reset during CMD_WAIT
        clear_log();
        m_mode = 2;
        set_req(0, 2'b10, 12'd30, CFGA, WDA);
        for (int i = 0; i < 50 && lg_cmd.size() == 0; i++) @(negedge clk);
        chk("t5_st", 144'(lg_cmd.size()), 144'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t5_out", 144'({gnt, rsp_valid, rsp_err, rsp_timeout,
            ctrl_start, ctrl_cmd, ctrl_addr, ctrl_cfg}), 144'(0));
        chk("t5_mem", ctrl_mem_in, 144'(0));
        rst = 1'b0;
        nr  = 0;
        repeat (10) begin
            @(negedge clk);
            if (|rsp_valid) nr++;
        end
        chk("t5_norsp", 144'(nr), 144'(0));
        clear_log();
        m_mode = 0;
        set_req(0, 2'b11, 12'd30, CFGA, '0);
        wait_rsp(who, rv, d, e, t, el);
        chk("t5_cold", 144'({lg_cmd.size(), 2'(lg_cmd[0])}),
            144'({32'd2, 2'b01}));

        // Contention after reset: 0,1,0,1 with a SET_VAR each time
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        glog.delete();
        @(negedge clk);
        ld(0, 2'b10, 12'd30, CFGA, WDA);
        ld(1, 2'b10, 12'd40, CFGB, WDB);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(who, rv, d, e, t, el);
            chk($sformatf("t6_who%0d", k), 144'(who), 144'(k % 2));
            chk($sformatf("t6_err%0d", k), 144'({e, t}), 144'(0));
            if (k < 2) begin
                @(negedge clk);
                if (who == 0) ld(0, 2'b10, 12'd30, CFGA, WDA);
                else          ld(1, 2'b10, 12'd40, CFGB, WDB);
            end
        end
        chk("t6_n", 144'(lg_cmd.size()), 144'(8));
        chk("t6_gn", 144'(glog.size()), 144'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_g%0d", i), 144'(glog[i]), 144'(i % 2));
            chk($sformatf("t6_sv%0d", i), 144'({lg_cmd[2*i], lg_cfg[2*i]}),
                144'({2'b01, (i % 2 == 1) ? CFGB : CFGA}));
            chk($sformatf("t6_wr%0d", i), 144'(lg_cmd[2*i+1]), 144'(2'b10));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/trng_cmd_arbiter.md
Name: trng_cmd_arbiter

Overview:
- Shares one TRNG_CTRL command port (TRNG / SET_VAR / WRITE / READ) between NUM_REQ requesters, e.g. host bus and a TRNG refill engine.
- Arbitrates round-robin and caches the loaded configuration, issuing SET_VAR only when a winner's config differs.
- Drives the controller's start/CMD/operand pins with fixed setup/pulse timing, waits for completion or timeout, and returns data/status to the winner.

Parameters:
- NUM_REQ, 2: number of requesters.
- SETUP_CYC, 2: cycles CMD/operands are stable before start rises.
- START_CYC, 2: start pulse width in cycles.
- TIMEOUT_CYC, 20000: max cycles from start rise to completion.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  request per requester; level, held until that requester's rsp_valid.
- req_cmd  in  2*NUM_REQ  packed command: 00 TRNG, 01 SET_VAR, 10 WRITE, 11 READ.
- req_addr  in  12*NUM_REQ  packed address.
- req_cfg  in  28*NUM_REQ  packed config {DETOUR[1:0], RP_SEL, DMODE_WRITE[5:0], DMODE_READ[5:0], TRNG_BIT[2:0], TRNG_MODE[8:0], DATA_TRNG}.
- req_wdata  in  144*NUM_REQ  packed write data.
- gnt  out  NUM_REQ  one-hot; high for exactly the cycle the winner's inputs are latched.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_data  out  144  MEM_OUT captured at completion; valid with rsp_valid.
- rsp_err  out  1  error status; valid with rsp_valid.
- rsp_timeout  out  1  timeout status; valid with rsp_valid.
- ctrl_start  out  1  to controller start.
- ctrl_cmd  out  2  to CMD.
- ctrl_addr  out  12  to ADDR.
- ctrl_cfg  out  28  to DETOUR_IN/RP_SEL_IN/DMODE_WRITE/DMODE_READ/TRNG_BIT/TRNG_MODE_IN/DATA_TRNG (same packing as req_cfg).
- ctrl_mem_in  out  144  to MEM_IN.
- ctrl_done  in  1  controller Done.
- ctrl_err  in  1  controller err.
- ctrl_mem_out  in  144  controller MEM_OUT.

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer -> requester 0 has highest priority; cfg_valid=0; loaded_cfg=0.
- Only one transaction in flight; req seen outside IDLE waits.
- IDLE: if any req, register winner = first set bit searching upward (with wrap) from last_winner+1. Pulse gnt; latch cmd/addr/cfg/wdata. Go to CFG_SETUP if cmd==SET_VAR, or !cfg_valid, or cfg!=loaded_cfg; else CMD_SETUP.
- CFG_SETUP: ctrl_cmd=01, ctrl_cfg=latched cfg; hold SETUP_CYC cycles; then CFG_START.
- CFG_START: ctrl_start=1 for START_CYC cycles; then CFG_WAIT.
- CFG_WAIT: completion = ctrl_done|ctrl_err, counted from start rise; the first completion cycle may fall inside the pulse.
  - On completion: if ctrl_err, go to RESP with err=1 and cfg_valid=0, skipping the command.
  - Otherwise loaded_cfg=cfg and cfg_valid=1. If latched cmd==SET_VAR go to RESP (err=0); else CMD_SETUP.
- CMD_SETUP: ctrl_cmd, ctrl_addr, ctrl_mem_in driven (ctrl_mem_in only for WRITE, else 0); hold SETUP_CYC; then CMD_START -> CMD_WAIT, same pulse/completion rule as the config path.
- CMD_WAIT completion: capture ctrl_mem_out if READ or TRNG, else 0; capture ctrl_err. Go to RESP.
- ctrl_cmd, ctrl_addr, ctrl_cfg, ctrl_mem_in stay stable from SETUP entry until the state after completion.
- Timeout: cycle counter clears at start rise. Reaching TIMEOUT_CYC without completion -> RESP with err=1, timeout=1, data=0, cfg_valid=0.
- RESP: rsp_valid[winner] for 1 cycle; last_winner=winner; ctrl_start=0; then IDLE. Next arbitration is no earlier than the following cycle.
- Latency, cached config: gnt at T0; ctrl_cmd valid at T1; ctrl_start high T1+SETUP_CYC .. T1+SETUP_CYC+START_CYC-1; rsp_valid 1 cycle after completion is sampled.
- A requester dropping req mid-transaction has no effect: the transaction completes and rsp_valid still pulses.
- Completion and timeout in the same cycle: completion wins.
- rst mid-operation: everything returns to reset values at that edge (ctrl_start low next cycle); cfg_valid=0 forces SET_VAR first on the next request.

Test Plan:
- Single WRITE, cold cache: req0 with cfg {10,1,3F,15,0,1A5,1}, addr 30, wdata 0x9876...89. Expect SET_VAR then WRITE on ctrl port, each with start high 2 cycles after 2 setup cycles. rsp_valid[0], rsp_err=0.
- READ, same config: no SET_VAR issued. ctrl_cmd=11, addr 30. ctrl_mem_out=0x...123456 at ctrl_done -> rsp_data equals it.
- Contention: req0 and req1 both high from IDLE. Grants go 0, 1, 0, 1 over 4 back-to-back requests. req1 with a different TRNG_MODE (0x077 vs 0x1A5) forces SET_VAR on every alternation.
- Address error: WRITE addr 3000 with ctrl_err pulsing and no ctrl_done -> rsp_err=1, rsp_timeout=0, cfg cache retained (next request issues no SET_VAR).
- Timeout: TIMEOUT_CYC=50, never assert done/err -> rsp_valid at start+50 (+1 RESP cycle) with err=1, timeout=1; next request reissues SET_VAR.
- Reset during CMD_WAIT: rst for 1 cycle -> all outputs 0 next cycle, no rsp_valid; re-request issues SET_VAR first.
